// File: rtl/fifo_rr_drain_if.sv
// Lane-side FIFO handshake and registered output port of the round-robin drain.
// The master modport is the drain; the slave modport is the FIFOs plus the downstream sink.
interface fifo_rr_drain_if #(
    parameter int N_LANES = 4,
    parameter int WIDTH   = 8,
    parameter int LANE_W  = $clog2(N_LANES)
);
    logic                       en;
    logic [N_LANES-1:0]         fifo_empty;
    logic [N_LANES*WIDTH-1:0]   fifo_q;
    logic [N_LANES-1:0]         fifo_rd;
    logic                       out_valid;
    logic [WIDTH-1:0]           out_data;
    logic [LANE_W-1:0]          out_lane;
    logic                       out_ready;
    logic [31:0]                grant_cnt;
    logic                       idle;

    modport master (
        input  en, fifo_empty, fifo_q, out_ready,
        output fifo_rd, out_valid, out_data, out_lane, grant_cnt, idle
    );

    modport slave (
        output en, fifo_empty, fifo_q, out_ready,
        input  fifo_rd, out_valid, out_data, out_lane, grant_cnt, idle
    );
endinterface

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of N_LANES FIFOs into a single output register, allowing up to
// BURST back-to-back pops from one lane before the scan moves on.
module fifo_rr_drain #(
    parameter int N_LANES = 4,
    parameter int WIDTH   = 8,
    parameter int BURST   = 4,
    parameter int LANE_W  = $clog2(N_LANES)
) (
    input  logic            clk,
    input  logic            rstn,
    fifo_rr_drain_if.master bus
);
    // state   | meaning
    // S_IDLE  | burst_cnt == 0; the next grant comes from a round-robin scan
    // S_BURST | burst_cnt >  0; cur_lane is re-granted while non-empty and below BURST
    localparam int              BC_W      = $clog2(BURST + 1);
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(BURST);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t              w_state;
    logic [LANE_W-1:0]   r_cur_lane;
    logic [LANE_W-1:0]   w_cur_lane_nxt;
    logic [BC_W-1:0]     r_burst_cnt;
    logic [BC_W-1:0]     w_burst_cnt_nxt;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [LANE_W-1:0]   r_out_lane;
    logic [31:0]         r_grant_cnt;
    logic                w_slot_free;
    logic                w_stay;
    logic                w_found;
    logic                w_grant;
    logic [LANE_W-1:0]   w_scan_lane;
    logic [LANE_W-1:0]   w_sel;
    logic [N_LANES-1:0]  w_rd;

    assign w_state     = (r_burst_cnt == '0) ? S_IDLE : S_BURST;
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_stay      = (w_state == S_BURST) && (r_burst_cnt < BURST_MAX)
                         && !bus.fifo_empty[r_cur_lane];

    // Scan from the farthest lane toward cur_lane+1 so the nearest non-empty lane wins.
    always_comb begin
        int                idx;
        logic [LANE_W-1:0] lane;
        idx         = 0;
        lane        = '0;
        w_found     = 1'b0;
        w_scan_lane = r_cur_lane;
        for (int k = N_LANES; k >= 1; k--) begin
            idx = int'(r_cur_lane) + k;
            if (idx >= N_LANES) idx = idx - N_LANES;
            lane = LANE_W'(idx);
            if (!bus.fifo_empty[lane]) begin
                w_found     = 1'b1;
                w_scan_lane = lane;
            end
        end
    end

    assign w_sel   = w_stay ? r_cur_lane : w_scan_lane;
    assign w_grant = rstn && bus.en && w_slot_free && w_found;

    always_comb begin
        w_rd = '0;
        if (w_grant) w_rd[w_sel] = 1'b1;
    end

    always_comb begin
        w_cur_lane_nxt  = r_cur_lane;
        w_burst_cnt_nxt = r_burst_cnt;
        if (w_grant) begin
            if (w_stay) begin
                w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            end else begin
                w_cur_lane_nxt  = w_sel;
                w_burst_cnt_nxt = BC_W'(1);
            end
        end else if (!bus.en || w_slot_free) begin
            // Opportunity with nothing to pop, or grants disabled: the burst ends.
            w_burst_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cur_lane  <= LANE_W'(N_LANES - 1);
            r_burst_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_grant_cnt <= '0;
        end else begin
            r_cur_lane  <= w_cur_lane_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.fifo_q[int'(w_sel)*WIDTH +: WIDTH];
                r_out_lane  <= w_sel;
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end else if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd   = w_rd;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_lane  = r_out_lane;
    assign bus.grant_cnt = r_grant_cnt;
    assign bus.idle      = (&bus.fifo_empty) && !r_out_valid;
endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: lane FIFOs are queues, expected behaviour comes from a
// queue-level arbitration model, with literal checks on the directed scenarios.
module tb_fifo_rr_drain;
    localparam int N = 4;
    localparam int W = 8;
    localparam int B = 4;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    fifo_rr_drain_if #(.N_LANES(N), .WIDTH(W)) bus ();

    fifo_rr_drain #(.N_LANES(N), .WIDTH(W), .BURST(B)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] q [N][$];

    // Model state
    int           m_cur;
    int           m_burst;
    bit           m_ov;
    logic [W-1:0] m_od;
    int           m_ol;
    logic [31:0]  m_gc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < N; i++) begin
            bus.fifo_empty[i] = (q[i].size() == 0);
            bus.fifo_q[i*W +: W] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic model_reset();
        m_cur = N - 1; m_burst = 0; m_ov = 0; m_od = '0; m_ol = 0; m_gc = '0;
    endtask

    function automatic int pick(output bit stay);
        stay = 0;
        if (m_burst > 0 && m_burst < B && q[m_cur].size() > 0) begin
            stay = 1;
            return m_cur;
        end
        for (int k = 1; k <= N; k++) begin
            int l;
            l = (m_cur + k) % N;
            if (q[l].size() > 0) return l;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
        return 1;
    endfunction

    // One clock: inputs already set at the negedge; checks before and after the edge.
    task automatic cycle(output int g);
        int           sel;
        bit           stay;
        bit           slot;
        bit           grant;
        logic [N-1:0] exp_rd;
        drive_fifo();
        #1;
        slot   = !m_ov || bus.out_ready;
        sel    = pick(stay);
        grant  = rstn && bus.en && slot && (sel >= 0);
        exp_rd = grant ? (N'(1) << sel) : '0;
        chk("fifo_rd", bus.fifo_rd, exp_rd);
        chk("rd_on_empty", bus.fifo_rd & bus.fifo_empty, 0);
        chk("idle", bus.idle, all_empty() && !m_ov);
        @(posedge clk);
        #1;
        g = -1;
        if (!rstn) begin
            model_reset();
        end else if (grant) begin
            m_od = q[sel].pop_front();
            m_ol = sel; m_ov = 1; m_gc = m_gc + 1; g = sel;
            if (stay) m_burst++;
            else begin m_cur = sel; m_burst = 1; end
        end else begin
            if (slot) m_ov = 0;
            if (!bus.en || slot) m_burst = 0;
        end
        drive_fifo();
        chk("out_valid", bus.out_valid, m_ov);
        chk("out_data", bus.out_data, m_od);
        chk("out_lane", bus.out_lane, m_ol);
        chk("grant_cnt", bus.grant_cnt, m_gc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        int g;
        for (int i = 0; i < N; i++) q[i].delete();
        rstn = 0; bus.en = 1; bus.out_ready = 1;
        cycle(g); cycle(g);
        rstn = 1;
    endtask

    task automatic drain();
        int g;
        int n;
        bus.en = 1; bus.out_ready = 1; n = 0;
        while (!(all_empty() && !m_ov) && n < 200) begin cycle(g); n++; end
        chk("drain_done", n < 200, 1);
    endtask

    initial begin
        int           g;
        int           lanes[$];
        int           exp38[24];
        logic [W-1:0] v;
        n_checks = 0; n_fail = 0;
        model_reset();
        rstn = 0; bus.en = 1; bus.out_ready = 1;
        for (int i = 0; i < N; i++) q[i].push_back(W'(8'hA0 + i));
        drive_fifo();
        @(negedge clk);

        // Reset with every lane non-empty, then first grant goes to lane 0.
        cycle(g); cycle(g);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_grant_cnt", bus.grant_cnt, 0);
        chk("rst_no_grant", g, -1);
        rstn = 1;
        cycle(g);
        chk("first_grant_lane", g, 0);
        chk("first_grant_data", bus.out_data, 8'hA0);
        drain();

        // Single lane 2 with three items.
        do_reset();
        q[2].push_back(8'h11); q[2].push_back(8'h22); q[2].push_back(8'h33);
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            chk("l2_lane", g, 2);
            chk("l2_out_lane", bus.out_lane, 2);
            v = W'(8'h11 * (i + 1));
            chk("l2_data", bus.out_data, v);
        end
        cycle(g);
        chk("l2_end_valid", bus.out_valid, 0);
        chk("l2_end_idle", bus.idle, 1);

        // Four full lanes: bursts of 4 then 2.
        do_reset();
        for (int i = 0; i < N; i++) for (int j = 0; j < 6; j++) q[i].push_back(W'(i*16 + j));
        for (int i = 0; i < 24; i++) begin
            cycle(g);
            lanes.push_back(g);
        end
        for (int i = 0; i < 24; i++) exp38[i] = (i < 16) ? (i / 4) : ((i - 16) / 2);
        for (int i = 0; i < 24; i++) chk("rr_order", lanes[i], exp38[i]);
        chk("rr_grant_cnt", bus.grant_cnt, 24);
        drain();

        // Backpressure: output holds, no pops, resume pops in the same cycle.
        do_reset();
        q[0].push_back(8'hC0); q[0].push_back(8'hC1); q[0].push_back(8'hC2);
        cycle(g);
        chk("bp_first", g, 0);
        bus.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(g);
            chk("bp_hold_grant", g, -1);
            chk("bp_hold_data", bus.out_data, 8'hC0);
        end
        bus.out_ready = 1;
        cycle(g);
        chk("bp_resume_lane", g, 0);
        chk("bp_resume_data", bus.out_data, 8'hC1);
        drain();

        // Lane 1 runs dry mid-burst, skip to lane 3; en drop mid-stream.
        do_reset();
        q[1].push_back(8'h51); q[1].push_back(8'h52);
        q[3].push_back(8'h71); q[3].push_back(8'h72);
        cycle(g); chk("skip_g1", g, 1);
        cycle(g); chk("skip_g2", g, 1);
        cycle(g); chk("skip_g3", g, 3);
        bus.en = 0;
        cycle(g);
        chk("en_low_grant", g, -1);
        chk("en_low_drained", bus.out_valid, 0);
        bus.en = 1;
        cycle(g); chk("en_back_lane", g, 3);
        chk("en_back_data", bus.out_data, 8'h72);
        cycle(g);
        chk("final_idle", bus.idle, 1);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int lane;
            for (int p = 0; p < 2; p++) begin
                lane = int'($urandom_range(N - 1));
                if ($urandom_range(99) < 35 && q[lane].size() < 8)
                    q[lane].push_back(W'($urandom));
            end
            bus.en        = ($urandom_range(99) < 85);
            bus.out_ready = ($urandom_range(99) < 70);
            rstn          = ($urandom_range(299) != 0);
            cycle(g);
        end
        rstn = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
